// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier request front end.
package mult_pkg;

    localparam int OP_W_DEF  = 8;
    localparam int RES_W_DEF = 14;
    localparam int TAG_W_DEF = 2;

    // Controller states: issue from queue, pulse start, wait for done, hold response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Request as produced by the core's issue logic.
    typedef struct packed {
        logic [OP_W_DEF-1:0]  a;
        logic [OP_W_DEF-1:0]  b;
        logic [TAG_W_DEF-1:0] tag;
    } req_t;

endpackage

// File: rtl/mult_req_fifo.sv
// Small synchronous request FIFO with registered full/empty flags.
module mult_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_r;
    logic          empty_r;
    logic          do_push_s;
    logic          do_pop_s;
    logic [AW:0]   count_next_s;

    // Writes into a full FIFO and reads from an empty one are dropped.
    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;

    // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + (AW+1)'(1);
        end else if (!do_push_s && do_pop_s) begin
            count_next_s = count_r - (AW+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and flags; flags are registered from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (AW+1)'(DEPTH));
            empty_r <= (count_next_s == '0);
        end
    end

    // Storage array, cleared on reset so no stale request is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign full  = full_r;
    assign empty = empty_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Request front end for the sequential shift-add multiplier: queues requests,
// launches them one at a time, and returns tagged in-order responses with a
// watchdog that turns a missing completion into an error response.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_a,
    input  logic [OP_W-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_res,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [OP_W-1:0]  mul_a,
    output logic [OP_W-1:0]  mul_b,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [RES_W-1:0] mul_res,
    output logic             busy
);

    localparam int REQ_W = 2 * OP_W + TAG_W;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t             state_r;
    state_t             state_next_s;

    logic               fifo_push_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [REQ_W-1:0]   fifo_din_s;
    logic [REQ_W-1:0]   fifo_head_s;
    logic [OP_W-1:0]    head_a_s;
    logic [OP_W-1:0]    head_b_s;
    logic [TAG_W-1:0]   head_tag_s;

    logic               pop_s;
    logic               wd_clr_s;
    logic               wd_inc_s;
    logic               cap_ok_s;
    logic               cap_err_s;
    logic               rsp_done_s;

    logic [OP_W-1:0]    mul_a_r;
    logic [OP_W-1:0]    mul_b_r;
    logic [TAG_W-1:0]   tag_r;
    logic               mul_start_r;
    logic [WD_W-1:0]    wd_r;
    logic               rsp_valid_r;
    logic [RES_W-1:0]   rsp_res_r;
    logic [TAG_W-1:0]   rsp_tag_r;
    logic               rsp_err_r;

    // Queue: no bypass, so ready depends only on the registered full flag.
    assign fifo_push_s = req_valid && !fifo_full_s;
    assign fifo_din_s  = {req_a, req_b, req_tag};
    assign head_a_s    = fifo_head_s[REQ_W-1 -: OP_W];
    assign head_b_s    = fifo_head_s[TAG_W +: OP_W];
    assign head_tag_s  = fifo_head_s[TAG_W-1:0];

    mult_req_fifo #(
        .DEPTH (DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (fifo_head_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and datapath strobes; mul_done is only looked at in WAIT.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        wd_clr_s     = 1'b0;
        wd_inc_s     = 1'b0;
        cap_ok_s     = 1'b0;
        cap_err_s    = 1'b0;
        rsp_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LAUNCH: begin
                wd_clr_s     = 1'b1;
                state_next_s = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    cap_ok_s     = 1'b1;
                    state_next_s = RESP;
                end else if (wd_r == WD_LAST) begin
                    cap_err_s    = 1'b1;
                    state_next_s = RESP;
                end else begin
                    wd_inc_s     = 1'b1;
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done_s   = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand/tag load on pop, start pulse, watchdog and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            tag_r       <= '0;
            mul_start_r <= 1'b0;
            wd_r        <= '0;
            rsp_valid_r <= 1'b0;
            rsp_res_r   <= '0;
            rsp_tag_r   <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            if (pop_s) begin
                mul_a_r <= head_a_s;
                mul_b_r <= head_b_s;
                tag_r   <= head_tag_s;
            end
            // High exactly during the LAUNCH cycle.
            mul_start_r <= pop_s;
            if (wd_clr_s) begin
                wd_r <= '0;
            end else if (wd_inc_s) begin
                wd_r <= wd_r + WD_W'(1);
            end
            if (cap_ok_s) begin
                rsp_valid_r <= 1'b1;
                rsp_res_r   <= mul_res;
                rsp_tag_r   <= tag_r;
                rsp_err_r   <= 1'b0;
            end else if (cap_err_s) begin
                rsp_valid_r <= 1'b1;
                rsp_res_r   <= '0;
                rsp_tag_r   <= tag_r;
                rsp_err_r   <= 1'b1;
            end else if (rsp_done_s) begin
                rsp_valid_r <= 1'b0;
            end
        end
    end

    assign req_ready = !fifo_full_s;
    assign busy      = !fifo_empty_s || (state_r != IDLE);
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign mul_start = mul_start_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_res   = rsp_res_r;
    assign rsp_tag   = rsp_tag_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural multiplier stub
// and a queue-based in-order response model.
module tb_mult_seq_ctrl;

    localparam int RES_MOD = 1 << 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = 8'd0;
    logic [7:0]  req_b = 8'd0;
    logic [1:0]  req_tag = 2'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [13:0] rsp_res;
    logic [1:0]  rsp_tag;
    logic        rsp_err;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        mul_start;
    logic        mul_done_m = 1'b0;
    logic [13:0] mul_res_m = 14'd0;
    logic        busy;

    mult_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_done  (mul_done_m),
        .mul_res   (mul_res_m),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier stub: done rises 9 edges after the start edge and stays high
    // (stale) until the next start; it is never reset.
    int         stub_cnt = 0;
    logic [7:0] op_a_m = 8'd0;
    logic [7:0] op_b_m = 8'd0;
    bit         watch_m = 1'b0;
    int         glitch_cnt = 0;
    bit         no_done = 1'b0;

    always @(posedge clk) begin
        if (mul_start) begin
            stub_cnt   <= 9;
            mul_done_m <= 1'b0;
            op_a_m     <= mul_a;
            op_b_m     <= mul_b;
            watch_m    <= 1'b1;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (watch_m && rst && (mul_a !== op_a_m || mul_b !== op_b_m))
                glitch_cnt <= glitch_cnt + 1;
            if (stub_cnt == 1 && !no_done) begin
                mul_done_m <= 1'b1;
                mul_res_m  <= 14'((int'(mul_a) * int'(mul_b)) % RES_MOD);
            end
        end
        if (!rst) watch_m <= 1'b0;
    end

    typedef struct {
        int res;
        int tag;
        bit err;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] tag;
        int         exp_res;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   rsp_seen = 0;
    bit   last_acc = 1'b0;
    bit   expect_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = req_valid && req_ready;
        if (mul_start) start_cnt++;
        if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_res", rsp_res, e.res);
                check("rsp_tag", rsp_tag, e.tag);
                check("rsp_err", rsp_err, e.err);
            end
        end
        if (last_acc) begin
            e.err = expect_err;
            e.res = expect_err ? 0 : (int'(req_a) * int'(req_b)) % RES_MOD;
            e.tag = int'(req_tag);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_single(input logic [7:0] a, input logic [7:0] b,
                                input logic [1:0] tag, output int lat);
        req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        tick();
        check("req_accepted", last_acc, 1);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain(input int bound);
        int cyc = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < bound) begin
            tick();
            cyc++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        vec_t       vecs[7];
        int         lat, sent, cyc, base, unstable, valid_seen;
        logic [7:0] ba[6];
        logic [7:0] bb[6];
        logic       ready6;
        bit         seen6;
        logic [13:0] h_res;
        logic [1:0]  h_tag;
        logic        h_err;

        vecs[0] = '{8'd13,  8'd11,  2'd2, 143};
        vecs[1] = '{8'd255, 8'd255, 2'd1, 15873};
        vecs[2] = '{8'd0,   8'd77,  2'd3, 0};
        vecs[3] = '{8'd128, 8'd128, 2'd0, 0};
        vecs[4] = '{8'd200, 8'd100, 2'd1, 3616};
        vecs[5] = '{8'd1,   8'd255, 2'd2, 255};
        vecs[6] = '{8'd127, 8'd129, 2'd3, 16383};

        // Reset state.
        repeat (3) @(posedge clk);
        check("reset_outputs", {rsp_valid, rsp_res, rsp_tag, rsp_err, mul_a, mul_b, mul_start, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);

        // Table of single requests: latency, product, tag, one start pulse, held operands.
        for (int i = 0; i < 7; i++) begin
            start_cnt = 0;
            issue_single(vecs[i].a, vecs[i].b, vecs[i].tag, lat);
            check("single_latency", lat, 12);
            check("single_res", rsp_res, vecs[i].exp_res);
            check("single_tag", rsp_tag, vecs[i].tag);
            check("single_err", rsp_err, 0);
            tick();
            check("single_start_pulses", start_cnt, 1);
            check("single_idle_after", busy, 0);
        end
        check("operand_hold", glitch_cnt, 0);

        // Six back-to-back requests into a 4-deep queue.
        for (int i = 0; i < 6; i++) begin
            ba[i] = 8'($urandom);
            bb[i] = 8'($urandom);
        end
        base = rsp_seen; sent = 0; cyc = 0; seen6 = 1'b0; ready6 = 1'b1;
        while (sent < 6 && cyc < 100) begin
            req_valid = 1'b1; req_a = ba[sent]; req_b = bb[sent]; req_tag = 2'(sent);
            if (sent == 5 && !seen6) begin
                seen6 = 1'b1;
                ready6 = req_ready;
            end
            tick();
            if (last_acc) sent++;
            cyc++;
        end
        req_valid = 1'b0;
        check("burst_sent", sent, 6);
        check("ready_low_on_6th", ready6, 0);
        drain(400);
        check("burst_rsp_count", rsp_seen - base, 6);

        // Response backpressure: response held, next request not launched.
        rsp_ready = 1'b0;
        start_cnt = 0;
        req_valid = 1'b1; req_a = 8'd21; req_b = 8'd3; req_tag = 2'd1;
        tick();
        req_a = 8'd9; req_b = 8'd9; req_tag = 2'd2;
        tick();
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("hold_rsp_valid", rsp_valid, 1);
        h_res = rsp_res; h_tag = rsp_tag; h_err = rsp_err;
        check("hold_first_res", h_res, 63);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_res !== h_res || rsp_tag !== h_tag || rsp_err !== h_err || rsp_valid !== 1'b1)
                unstable++;
        end
        check("hold_stable", unstable, 0);
        check("hold_no_start", start_cnt, 1);
        rsp_ready = 1'b1;
        tick();
        cyc = 0;
        while (start_cnt < 2 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("launch_after_release", start_cnt, 2);
        drain(100);

        // Watchdog: no completion gives an error response after TIMEOUT WAIT cycles.
        no_done = 1'b1;
        expect_err = 1'b1;
        issue_single(8'd50, 8'd60, 2'd3, lat);
        check("timeout_latency", lat, 18);
        check("timeout_err", rsp_err, 1);
        check("timeout_res", rsp_res, 0);
        tick();
        no_done = 1'b0;
        expect_err = 1'b0;
        issue_single(8'd7, 8'd6, 2'd0, lat);
        check("after_timeout_latency", lat, 12);
        check("after_timeout_res", rsp_res, 42);
        tick();

        // Asynchronous reset in WAIT, then a clean request afterwards.
        req_valid = 1'b1; req_a = 8'd77; req_b = 8'd3; req_tag = 2'd1;
        tick();
        req_a = 8'd5; req_b = 8'd5; req_tag = 2'd2;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {rsp_valid, rsp_res, rsp_tag, rsp_err, mul_a, mul_b, mul_start, busy}, 64'd0);
        check("async_reset_fifo_empty", req_ready, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        valid_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid || busy) valid_seen++;
        end
        check("no_spurious_after_reset", valid_seen, 0);
        issue_single(8'd3, 8'd5, 2'd3, lat);
        check("post_reset_latency", lat, 12);
        check("post_reset_res", rsp_res, 15);
        tick();

        // Randomised traffic with random backpressure against the queue model.
        sent = 0; cyc = 0;
        while (sent < 24 && cyc < 3000) begin
            if (!req_valid && ($urandom % 4) != 0) begin
                req_valid = 1'b1;
                req_a = 8'($urandom);
                req_b = 8'($urandom);
                req_tag = 2'($urandom);
            end
            rsp_ready = 1'($urandom);
            tick();
            if (last_acc) begin
                sent++;
                req_valid = 1'b0;
            end
            cyc++;
        end
        req_valid = 1'b0;
        check("random_sent", sent, 24);
        drain(600);
        check("operand_hold_final", glitch_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
